// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the accumulator CPU: opcodes, FSM states,
// the JMP operand pattern that halts the machine, and a memory-op decoder.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NOT  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SHFT = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_CMP  = 3'b110,
    OP_JMP  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_e;

  // A JMP whose operand is all ones halts; only the low ADDR_W bits are compared.
  localparam logic [31:0] HALT_OPERAND = 32'hFFFF_FFFF;

  // Opcodes that spend their EXEC cycle(s) on a memory access at the operand address.
  function automatic logic isMemOp(input opcode_e op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LD) ||
           (op == OP_ST)  || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational datapath for the accumulator CPU: AND, NOT, ADD, SHFT and the
// unsigned compare that feeds the flags.
// Build option: define ACC_CPU_SAT_ADD_EN to make ADD saturate to all ones on
// unsigned carry-out instead of wrapping.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  opcode_e             op_i,
  input  logic [DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [ADDR_W-1:0]   operand_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                gt_o,
  output logic                lt_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] addResult;
  logic [DATA_W-1:0] shiftResult;
  logic [SH_W-1:0]   shiftAmt;
  logic              shiftLeft;
  logic              shiftArith;

  assign shiftLeft  = operand_i[ADDR_W-1];
  assign shiftArith = operand_i[ADDR_W-2];
  assign shiftAmt   = operand_i[SH_W-1:0];

`ifdef ACC_CPU_SAT_ADD_EN
  logic [DATA_W:0] sumFull;
  assign sumFull   = {1'b0, acc_i} + {1'b0, data_i};
  assign addResult = sumFull[DATA_W] ? {DATA_W{1'b1}} : sumFull[DATA_W-1:0];
`else
  assign addResult = acc_i + data_i;
`endif

  // Shifter: left is always logical; right shifts are logical or sign-filling.
  always_comb begin
    if (shiftLeft) begin
      shiftResult = acc_i << shiftAmt;
    end else if (shiftArith) begin
      shiftResult = $signed(acc_i) >>> shiftAmt;
    end else begin
      shiftResult = acc_i >> shiftAmt;
    end
  end

  // Result select; opcodes the ALU does not handle pass the accumulator through.
  always_comb begin
    result_o = acc_i;
    case (op_i)
      OP_AND:  result_o = acc_i & data_i;
      OP_NOT:  result_o = ~acc_i;
      OP_ADD:  result_o = addResult;
      OP_SHFT: result_o = shiftResult;
      default: result_o = acc_i;
    endcase
  end

  assign gt_o = (acc_i > data_i);
  assign lt_o = (acc_i < data_i);

endmodule

// File: rtl/acc_cpu.sv
// Accumulator CPU top: IDLE/FETCH/EXEC/HALT sequencer, pc, IR, accumulator and
// compare flags, with a req/rdy memory port shared by fetch and data accesses.
// Build option: ACC_CPU_SAT_ADD_EN (saturating ADD, implemented in acc_cpu_alu).
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halt,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              flag_p,
  output logic              flag_n
);

  localparam int OFF_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              flagP_q, flagP_d;
  logic              flagN_q, flagN_d;

  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] jmpOffset;
  logic              jmpHalt;
  logic              jmpTaken;
  logic              execDone;
  logic [DATA_W-1:0] aluResult;
  logic              aluGt;
  logic              aluLt;

  assign opcode    = opcode_e'(ir_q[DATA_W-1 -: 3]);
  assign operand   = ir_q[ADDR_W-1:0];
  assign jmpOffset = {{2{operand[OFF_W-1]}}, operand[OFF_W-1:0]};
  assign jmpHalt   = (operand == HALT_OPERAND[ADDR_W-1:0]);
  assign jmpTaken  = (operand[ADDR_W-1:ADDR_W-2] == 2'b11) ||
                     ({flagN_q, flagP_q} == operand[ADDR_W-1:ADDR_W-2]);

  acc_cpu_alu #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu (
    .op_i      (opcode),
    .acc_i     (acc_q),
    .data_i    (mem_rdata),
    .operand_i (operand),
    .result_o  (aluResult),
    .gt_o      (aluGt),
    .lt_o      (aluLt)
  );

  // Architectural state; reset abandons any pending access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      flagP_q <= 1'b0;
      flagN_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      flagP_q <= flagP_d;
      flagN_q <= flagN_d;
    end
  end

  // Sequencer and memory port. Port outputs derive only from registered state,
  // so they hold steady while an access waits for mem_rdy.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    flagP_d   = flagP_q;
    flagN_d   = flagN_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    execDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_rdy) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (isMemOp(opcode)) begin
          mem_req  = 1'b1;
          mem_addr = operand;
          if (opcode == OP_ST) begin
            mem_we    = 1'b1;
            mem_wdata = acc_q;
          end
          execDone = mem_rdy;
        end else begin
          execDone = 1'b1;
        end
        if (execDone) begin
          case (opcode)
            OP_AND, OP_NOT, OP_ADD, OP_SHFT: acc_d = aluResult;
            OP_LD: acc_d = mem_rdata;
            OP_CMP: begin
              flagP_d = aluGt;
              flagN_d = aluLt;
            end
            OP_JMP: begin
              if (!jmpHalt && jmpTaken) begin
                pc_d = pc_q + jmpOffset;
              end
            end
            default: acc_d = acc_q;
          endcase
          if ((opcode == OP_JMP) && jmpHalt) begin
            state_d = HALT;
          end else if (start) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign halt   = (state_q == HALT);
  assign busy   = (state_q == FETCH) || (state_q == EXEC);
  assign flag_p = flagP_q;
  assign flag_n = flagN_q;

endmodule
